// File: rtl/line_fill_server.sv
// line_fill_server: serves 128-bit cache line fills from a local line array with a fixed
// accept-to-data latency. Optional single-word write port enabled by the macro
// LINE_FILL_SERVER_WRITE_EN; without it the array is read-only.
module line_fill_server #(
   parameter int unsigned LINES   = 256,
   parameter int unsigned LATENCY = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         i_req,
   input  logic [31:0]  i_addr,
   input  logic         i_we,
   input  logic [31:0]  i_waddr,
   input  logic [31:0]  i_wdata,
   output logic [127:0] o_miss_data,
   output logic         o_valid,
   output logic         o_busy
);

   localparam int unsigned IdxW = $clog2(LINES);
   localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [IdxW-1:0]   line_q, line_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic [127:0]      data_q, data_d;

   logic [127:0]      mem_q [LINES];

   logic              wr_en;
   logic [IdxW-1:0]   wr_line;
   logic [1:0]        wr_word;

`ifdef LINE_FILL_SERVER_WRITE_EN
   assign wr_en = i_we;
`else
   assign wr_en = 1'b0;
`endif

   assign wr_line = i_waddr[IdxW+3:4];
   assign wr_word = i_waddr[3:2];

   // Address bits outside the line index / word select are dropped on purpose (aliasing).
   logic unused_bits;
   assign unused_bits = ^{i_addr[31:IdxW+4], i_addr[3:0], i_waddr[31:IdxW+4], i_waddr[1:0], i_we};

   // Next-state and output logic for the fill sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      line_d  = line_q;
      valid_d = 1'b0;
      busy_d  = busy_q;
      data_d  = data_q;
      unique case (state_q)
         StIdle: begin
            if (i_req) begin
               line_d  = i_addr[IdxW+3:4];
               cnt_d   = CntW'(LATENCY - 1);
               busy_d  = 1'b1;
               state_d = StWait;
            end
         end
         StWait: begin
            if (cnt_q == '0) begin
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StResp: begin
            // Read happens here so writes landing during the wait are returned.
            data_d  = mem_q[line_q];
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         line_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         data_q  <= data_d;
      end
   end

   // Line array word write; never reset, and blocked while reset is held. The RESP read
   // above samples the pre-write contents when both hit the same line on one edge.
   always_ff @(posedge clk) begin
      if (!rstn && wr_en) begin
         mem_q[wr_line][{wr_word, 5'd0} +: 32] <= i_wdata;
      end
   end

   assign o_miss_data = data_q;
   assign o_valid     = valid_q;
   assign o_busy      = busy_q;

endmodule

// File: tb/tb_line_fill_server.sv
// Bench for line_fill_server: random and directed stimulus checked against a
// latency-countdown reference model of the line array. Honours LINE_FILL_SERVER_WRITE_EN.
module tb_line_fill_server;

   localparam int unsigned LINES   = 256;
   localparam int unsigned LATENCY = 4;
`ifdef LINE_FILL_SERVER_WRITE_EN
   localparam bit WrEn = 1'b1;
`else
   localparam bit WrEn = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rstn;
   logic         i_req;
   logic [31:0]  i_addr;
   logic         i_we;
   logic [31:0]  i_waddr;
   logic [31:0]  i_wdata;
   logic [127:0] o_miss_data;
   logic         o_valid;
   logic         o_busy;

   line_fill_server #(.LINES(LINES), .LATENCY(LATENCY)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .i_req       (i_req),
      .i_addr      (i_addr),
      .i_we        (i_we),
      .i_waddr     (i_waddr),
      .i_wdata     (i_wdata),
      .o_miss_data (o_miss_data),
      .o_valid     (o_valid),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   // Reference model: line contents plus an in-flight fill counting down to its data edge.
   logic [127:0] mem_m [LINES];
   bit           m_valid;
   bit           m_busy;
   logic [127:0] m_data;
   int           m_left;
   int           m_line;
   int           cyc;

   int n_vec;
   int n_err;

   task automatic step(input bit rst, input bit req, input logic [31:0] addr,
                       input bit we, input logic [31:0] waddr, input logic [31:0] wdata);
      int ln;
      int wd;
      rstn    = rst;
      i_req   = req;
      i_addr  = addr;
      i_we    = we;
      i_waddr = waddr;
      i_wdata = wdata;
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0;
         m_busy  = 1'b0;
         m_left  = 0;
         m_data  = '0;
      end else begin
         m_valid = 1'b0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_valid = 1'b1;
               m_data  = mem_m[m_line];
               m_busy  = 1'b0;
            end
         end else if (req) begin
            m_busy = 1'b1;
            m_left = LATENCY + 1;
            m_line = int'((addr >> 4) % LINES);
         end
         if (WrEn && we) begin
            ln = int'((waddr >> 4) % LINES);
            wd = int'((waddr >> 2) % 4);
            mem_m[ln][wd*32 +: 32] = wdata;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
         n_vec++;
         if ({o_valid, o_busy, o_miss_data} !== 130'd0) begin
            n_err++;
            $display("FAIL reset_state cyc=%0d got v=%0b b=%0b d=%h want all zero",
                     cyc, o_valid, o_busy, o_miss_data);
         end
      end
   endtask

   task automatic test_basic_fill();
      int first = -1;
      step(1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0, 32'h0);
      for (int k = 1; k <= 8; k++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
         if (o_valid && first < 0) first = k;
         n_vec++;
         if ({o_valid, o_busy, o_miss_data} !== {m_valid, m_busy, m_data}) begin
            n_err++;
            $display("FAIL basic_fill cyc=%0d got v=%0b b=%0b d=%h want v=%0b b=%0b d=%h",
                     cyc, o_valid, o_busy, o_miss_data, m_valid, m_busy, m_data);
         end
      end
      n_vec++;
      if (first !== 5) begin
         n_err++;
         $display("FAIL basic_latency got %0d edges want 5", first);
      end
      n_vec++;
      if (o_miss_data[31:0] !== 32'h0043_0820) begin
         n_err++;
         $display("FAIL basic_word0 got %h want 00430820", o_miss_data[31:0]);
      end
   endtask

   task automatic test_back_to_back();
      int  rises[$];
      bit  prev = o_busy;
      for (int c = 0; c <= 18; c++) begin
         step(1'b0, c <= 12, $urandom, 1'b0, 32'h0, 32'h0);
         if (o_busy && !prev) rises.push_back(c);
         prev = o_busy;
         n_vec++;
         if ({o_valid, o_busy, o_miss_data} !== {m_valid, m_busy, m_data}) begin
            n_err++;
            $display("FAIL back_to_back cyc=%0d got v=%0b b=%0b d=%h want v=%0b b=%0b d=%h",
                     cyc, o_valid, o_busy, o_miss_data, m_valid, m_busy, m_data);
         end
      end
      n_vec++;
      if (rises.size() !== 3 || rises[0] !== 0 || rises[1] !== 6 || rises[2] !== 12) begin
         n_err++;
         $display("FAIL back_to_back_accepts got %0d accepts (%p) want 0,6,12", rises.size(),
                  rises);
      end
   endtask

   task automatic test_write();
      logic [31:0] orig;
      logic [31:0] want;
      // Write then fill.
      orig = mem_m[2][63:32];
      want = WrEn ? 32'hDEAD_BEEF : orig;
      for (int k = 0; k <= 6; k++) begin
         step(1'b0, k == 1, 32'h20, k == 0, 32'h24, 32'hDEAD_BEEF);
         n_vec++;
         if ({o_valid, o_busy, o_miss_data} !== {m_valid, m_busy, m_data}) begin
            n_err++;
            $display("FAIL write_then_fill cyc=%0d got v=%0b b=%0b d=%h want v=%0b b=%0b d=%h",
                     cyc, o_valid, o_busy, o_miss_data, m_valid, m_busy, m_data);
         end
      end
      n_vec++;
      if (o_miss_data[63:32] !== want) begin
         n_err++;
         $display("FAIL write_then_fill_word got %h want %h", o_miss_data[63:32], want);
      end
      // Write to the pending line while waiting.
      orig = mem_m[2][95:64];
      want = WrEn ? 32'h1234_5678 : orig;
      for (int k = 0; k <= 5; k++) begin
         step(1'b0, k == 0, 32'h20, k == 2, 32'h28, 32'h1234_5678);
         n_vec++;
         if ({o_valid, o_busy, o_miss_data} !== {m_valid, m_busy, m_data}) begin
            n_err++;
            $display("FAIL write_in_wait cyc=%0d got v=%0b b=%0b d=%h want v=%0b b=%0b d=%h",
                     cyc, o_valid, o_busy, o_miss_data, m_valid, m_busy, m_data);
         end
      end
      n_vec++;
      if (o_valid !== 1'b1 || o_miss_data[95:64] !== want) begin
         n_err++;
         $display("FAIL write_in_wait_word got v=%0b %h want v=1 %h", o_valid,
                  o_miss_data[95:64], want);
      end
      // Write on the response edge: old word out, new word on the next fill.
      orig = mem_m[3][31:0];
      for (int k = 0; k <= 5; k++) begin
         step(1'b0, k == 0, 32'h30, k == 5, 32'h30, 32'hCAFE_F00D);
         n_vec++;
         if ({o_valid, o_busy, o_miss_data} !== {m_valid, m_busy, m_data}) begin
            n_err++;
            $display("FAIL write_on_resp cyc=%0d got v=%0b b=%0b d=%h want v=%0b b=%0b d=%h",
                     cyc, o_valid, o_busy, o_miss_data, m_valid, m_busy, m_data);
         end
      end
      n_vec++;
      if (o_valid !== 1'b1 || o_miss_data[31:0] !== orig) begin
         n_err++;
         $display("FAIL write_on_resp_old got v=%0b %h want v=1 %h", o_valid,
                  o_miss_data[31:0], orig);
      end
      want = WrEn ? 32'hCAFE_F00D : orig;
      for (int k = 0; k <= 5; k++) begin
         step(1'b0, k == 0, 32'h30, 1'b0, 32'h0, 32'h0);
      end
      n_vec++;
      if (o_valid !== 1'b1 || o_miss_data[31:0] !== want) begin
         n_err++;
         $display("FAIL write_on_resp_new got v=%0b %h want v=1 %h", o_valid,
                  o_miss_data[31:0], want);
      end
   endtask

   task automatic test_reset_mid_fill();
      bit seen = 1'b0;
      int first = -1;
      for (int k = 0; k <= 2; k++) step(1'b0, k == 0, 32'h40, 1'b0, 32'h0, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      n_vec++;
      if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_fill got b=%0b v=%0b want b=0 v=0", o_busy, o_valid);
      end
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
         if (o_valid) seen = 1'b1;
      end
      n_vec++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL reset_abort got a valid pulse want none");
      end
      step(1'b0, 1'b1, 32'h50, 1'b0, 32'h0, 32'h0);
      for (int k = 1; k <= 7; k++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
         if (o_valid && first < 0) first = k;
      end
      n_vec++;
      if (first !== 5 || o_miss_data !== mem_m[5]) begin
         n_err++;
         $display("FAIL reset_then_fill got latency %0d d=%h want 5 d=%h", first, o_miss_data,
                  mem_m[5]);
      end
   endtask

   task automatic test_alias();
      logic [127:0] d1;
      for (int k = 0; k <= 5; k++) step(1'b0, k == 0, 32'h10, 1'b0, 32'h0, 32'h0);
      d1 = o_miss_data;
      for (int k = 0; k <= 5; k++) step(1'b0, k == 0, LINES * 16 + 32'h10, 1'b0, 32'h0, 32'h0);
      n_vec++;
      if (o_valid !== 1'b1 || o_miss_data !== d1 || o_miss_data !== m_data) begin
         n_err++;
         $display("FAIL alias got v=%0b d=%h want v=1 d=%h", o_valid, o_miss_data, m_data);
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] wa;
      for (int k = 0; k < 400; k++) begin
         a  = $urandom;
         wa = $urandom;
         if ($urandom_range(0, 1) == 1) a[31:6] = '0;
         if ($urandom_range(0, 1) == 1) wa[31:6] = '0;
         step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, a,
              $urandom_range(0, 2) == 0, wa, $urandom);
         n_vec++;
         if ({o_valid, o_busy, o_miss_data} !== {m_valid, m_busy, m_data}) begin
            n_err++;
            $display("FAIL random cyc=%0d got v=%0b b=%0b d=%h want v=%0b b=%0b d=%h",
                     cyc, o_valid, o_busy, o_miss_data, m_valid, m_busy, m_data);
         end
      end
      for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      cyc     = 0;
      m_valid = 1'b0;
      m_busy  = 1'b0;
      m_left  = 0;
      m_line  = 0;
      m_data  = '0;
      rstn    = 1'b1;
      i_req   = 1'b0;
      i_addr  = '0;
      i_we    = 1'b0;
      i_waddr = '0;
      i_wdata = '0;
      for (int i = 0; i < LINES; i++) begin
         mem_m[i] = {$urandom, $urandom, $urandom, $urandom};
      end
      mem_m[1] = {32'h20, 32'h20, 32'h20, 32'h0043_0820};
      for (int i = 0; i < LINES; i++) begin
         dut.mem_q[i] <= mem_m[i];
      end
      test_reset();
      test_basic_fill();
      test_back_to_back();
      test_write();
      test_reset_mid_fill();
      test_alias();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
